// File: rtl/load_store_unit.sv
// load_store_unit: sequencer between the execute stage and a word-addressed
// data memory. It handles byte/half/word loads and stores, does
// read-modify-write for sub-word stores, and returns extended load data
// with a one-cycle response pulse.
// Build option: define LSU_FAULT_CHECK_EN to reject illegal sizes,
// misaligned and out-of-range requests. Without it, addresses are aligned
// down and the word index wraps modulo MEM_WORDS.
module load_store_unit #(
  parameter int MEM_WORDS  = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic                  ReqWrite,
  input  logic [1:0]            ReqSize,
  input  logic                  ReqSigned,
  input  logic [ADDR_WIDTH-1:0] ReqAddr,
  input  logic [31:0]           ReqWData,
  output logic                  RespValid,
  output logic [31:0]           RespRData,
  output logic                  RespFault,
  output logic [ADDR_WIDTH-1:0] MemAddress,
  output logic [31:0]           MemWriteData,
  output logic                  MemRead,
  output logic                  MemWrite,
  input  logic [31:0]           MemReadData
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] READ    = 3'd1;
  localparam logic [2:0] CAPTURE = 3'd2;
  localparam logic [2:0] MERGE   = 3'd3;
  localparam logic [2:0] WRITE   = 3'd4;
  localparam logic [2:0] RESP    = 3'd5;

`ifdef LSU_FAULT_CHECK_EN
  localparam logic [ADDR_WIDTH-1:0] MEM_LIMIT = ADDR_WIDTH'(MEM_WORDS);
`else
  localparam logic [ADDR_WIDTH-1:0] IDX_MASK = ADDR_WIDTH'(MEM_WORDS - 1);
`endif

  logic [2:0]            state_r, next_s;
  logic                  write_r, signed_r;
  logic [1:0]            size_r, lane_r;
  logic [31:0]           wdata_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r;
  logic [31:0]           mem_wdata_r;
  logic                  mem_read_r, mem_write_r, resp_valid_r;
  logic [31:0]           resp_rdata_r;
  logic [1:0]            size_norm_s, lane_norm_s;
  logic [ADDR_WIDTH-1:0] idx_s;
`ifdef LSU_FAULT_CHECK_EN
  logic                  fault_s;
  logic                  resp_fault_r;
`endif

  // Select the addressed lane(s) and zero- or sign-extend them.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        sgn);
    logic [31:0] sh;
    sh = word >> {lane, 3'b000};
    case (size)
      2'b00:   return sgn ? {{24{sh[7]}}, sh[7:0]} : {24'h000000, sh[7:0]};
      2'b01:   return sgn ? {{16{sh[15]}}, sh[15:0]} : {16'h0000, sh[15:0]};
      default: return word;
    endcase
  endfunction

  // Replace only the addressed lane(s) of the read word with store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [31:0] wdata,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] mask;
    case (size)
      2'b00:   mask = 32'h000000FF;
      2'b01:   mask = 32'h0000FFFF;
      default: mask = 32'hFFFFFFFF;
    endcase
    return (word & ~(mask << {lane, 3'b000})) | ((wdata & mask) << {lane, 3'b000});
  endfunction

  // Decode the incoming request: normalised size, lane, word index, fault.
  always_comb begin
    idx_s = ReqAddr >> 2'd2;
    if (ReqSize == 2'b11) begin
      size_norm_s = 2'b10;
    end else begin
      size_norm_s = ReqSize;
    end
    case (size_norm_s)
      2'b00:   lane_norm_s = ReqAddr[1:0];
      2'b01:   lane_norm_s = {ReqAddr[1], 1'b0};
      default: lane_norm_s = 2'b00;
    endcase
`ifdef LSU_FAULT_CHECK_EN
    fault_s = (ReqSize == 2'b11) ||
              ((ReqSize == 2'b01) && ReqAddr[0]) ||
              ((ReqSize == 2'b10) && (ReqAddr[1:0] != 2'b00)) ||
              (idx_s >= MEM_LIMIT);
`else
    idx_s = idx_s & IDX_MASK;
`endif
  end

  // Next-state selection for the request sequencer.
  always_comb begin
    next_s = state_r;
    case (state_r)
      IDLE: begin
        if (!ReqValid) begin
          next_s = IDLE;
`ifdef LSU_FAULT_CHECK_EN
        end else if (fault_s) begin
          next_s = RESP;
`endif
        end else if (ReqWrite && (size_norm_s == 2'b10)) begin
          next_s = WRITE;
        end else begin
          next_s = READ;
        end
      end
      READ: begin
        if (write_r) begin
          next_s = MERGE;
        end else begin
          next_s = CAPTURE;
        end
      end
      CAPTURE: next_s = RESP;
      MERGE:   next_s = WRITE;
      WRITE:   next_s = RESP;
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // State register; strobes are registered from the state being entered.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_r      <= IDLE;
      mem_read_r   <= 1'b0;
      mem_write_r  <= 1'b0;
      resp_valid_r <= 1'b0;
    end else begin
      state_r      <= next_s;
      mem_read_r   <= (next_s == READ);
      mem_write_r  <= (next_s == WRITE);
      resp_valid_r <= (next_s == RESP);
    end
  end

  // Capture the request fields on acceptance.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      write_r  <= 1'b0;
      size_r   <= 2'b00;
      signed_r <= 1'b0;
      lane_r   <= 2'b00;
      wdata_r  <= 32'h00000000;
    end else if ((state_r == IDLE) && ReqValid) begin
      write_r  <= ReqWrite;
      size_r   <= size_norm_s;
      signed_r <= ReqSigned;
      lane_r   <= lane_norm_s;
      wdata_r  <= ReqWData;
    end
  end

  // Memory address held from acceptance through WRITE; write word built here.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      mem_addr_r  <= '0;
      mem_wdata_r <= 32'h00000000;
    end else begin
      if ((state_r == IDLE) && (next_s != IDLE) && (next_s != RESP)) begin
        mem_addr_r <= idx_s;
      end
      if ((state_r == IDLE) && (next_s == WRITE)) begin
        mem_wdata_r <= ReqWData;
      end else if (state_r == MERGE) begin
        mem_wdata_r <= merge_store(MemReadData, wdata_r, size_r, lane_r);
      end
    end
  end

  // Response data registered on entry to RESP and held until the next one.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      resp_rdata_r <= 32'h00000000;
    end else if (next_s == RESP) begin
      if (state_r == CAPTURE) begin
        resp_rdata_r <= extract_load(MemReadData, size_r, lane_r, signed_r);
      end else begin
        resp_rdata_r <= 32'h00000000;
      end
    end
  end

`ifdef LSU_FAULT_CHECK_EN
  // Fault flag: only a rejected request goes straight from IDLE to RESP.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      resp_fault_r <= 1'b0;
    end else if (next_s == RESP) begin
      resp_fault_r <= (state_r == IDLE);
    end
  end
  assign RespFault = resp_fault_r;
`else
  assign RespFault = 1'b0;
`endif

  assign ReqReady     = (state_r == IDLE);
  assign RespValid    = resp_valid_r;
  assign RespRData    = resp_rdata_r;
  assign MemAddress   = mem_addr_r;
  assign MemWriteData = mem_wdata_r;
  assign MemRead      = mem_read_r;
  assign MemWrite     = mem_write_r;

endmodule
